// File: rtl/segment_pkg.sv
// Shared definitions for 128-bit segment records exchanged between the host
// packer and the segment-clock generator.
package segment_pkg;

    localparam int REC_W   = 128;
    localparam int ON_W    = 48;
    localparam int OFF_W   = 48;
    localparam int REP_W   = 32;
    localparam int ON_LSB  = 80;
    localparam int OFF_LSB = 32;
    localparam int REP_LSB = 0;

    localparam logic [REC_W-1:0] MARKER_REC = 128'h0;

    typedef struct packed {
        logic [ON_W-1:0]  on_counts;
        logic [OFF_W-1:0] off_counts;
        logic [REP_W-1:0] repeat_counts;
    } seg_rec_t;

endpackage

// File: rtl/segment_record_validator.sv
// Combinational classifier for a completed segment record: all-zero retrigger
// marker, or a regular record whose three count fields must all be non-zero.
module segment_record_validator
    import segment_pkg::*;
(
    input  logic [REC_W-1:0] rec,
    output logic             is_marker,
    output logic             is_valid
);

    logic w_on_ok;
    logic w_off_ok;
    logic w_rep_ok;

    assign w_on_ok   = (rec[ON_LSB  +: ON_W]  != {ON_W{1'b0}});
    assign w_off_ok  = (rec[OFF_LSB +: OFF_W] != {OFF_W{1'b0}});
    assign w_rep_ok  = (rec[REP_LSB +: REP_W] != {REP_W{1'b0}});
    assign is_marker = (rec == MARKER_REC);
    assign is_valid  = is_marker | (w_on_ok & w_off_ok & w_rep_ok);

endmodule

// File: rtl/segment_record_packer.sv
// Packs host pipe words into segment records, validates them and hands them to
// the segment FIFO through a single-entry hold register.
module segment_record_packer
    import segment_pkg::*;
#(
    parameter int PIPE_W        = 16,
    parameter int WORDS_PER_REC = 8,
    parameter int CNT_W         = 16
) (
    input  logic              ti_clk,
    input  logic              reset,
    input  logic              pipe_write,
    input  logic [PIPE_W-1:0] pipe_data,
    input  logic              realign,
    input  logic              clear_flags,
    input  logic              fifo_full,
    output logic [REC_W-1:0]  rec_data,
    output logic              rec_write,
    output logic [2:0]        word_index,
    output logic [CNT_W-1:0]  records_pushed,
    output logic [7:0]        markers_pushed,
    output logic [7:0]        invalid_count,
    output logic              invalid_flag,
    output logic              overflow_flag
);

    logic [REC_W-1:0] r_asm;
    logic [2:0]       r_word_idx;
    logic [REC_W-1:0] r_hold;
    logic             r_hold_valid;
    logic             r_hold_marker;
    logic [CNT_W-1:0] r_pushed;
    logic [7:0]       r_markers;
    logic [7:0]       r_invalid;
    logic             r_invalid_flag;
    logic             r_overflow_flag;

    logic             w_take_word;
    logic             w_complete;
    logic [REC_W-1:0] w_full_rec;
    logic             w_is_marker;
    logic             w_is_valid;
    logic             w_drain;
    logic             w_accept;
    logic             w_overflow;
    logic             w_invalid;

    assign w_take_word = pipe_write & ~realign;
    assign w_complete  = w_take_word & (r_word_idx == 3'(WORDS_PER_REC - 1));
    assign w_full_rec  = {r_asm[REC_W-PIPE_W-1:0], pipe_data};

    segment_record_validator u_validator (
        .rec       (w_full_rec),
        .is_marker (w_is_marker),
        .is_valid  (w_is_valid)
    );

    // A draining hold register frees its slot for a record completing at the same edge.
    assign w_drain    = r_hold_valid & ~fifo_full;
    assign w_accept   = w_complete & w_is_valid & (~r_hold_valid | w_drain);
    assign w_overflow = w_complete & w_is_valid & r_hold_valid & ~w_drain;
    assign w_invalid  = w_complete & ~w_is_valid;

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            r_asm      <= {REC_W{1'b0}};
            r_word_idx <= 3'd0;
        end else if (realign) begin
            r_asm      <= {REC_W{1'b0}};
            r_word_idx <= 3'd0;
        end else if (pipe_write) begin
            r_asm      <= w_full_rec;
            r_word_idx <= r_word_idx + 3'd1;
        end
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            r_hold        <= {REC_W{1'b0}};
            r_hold_valid  <= 1'b0;
            r_hold_marker <= 1'b0;
        end else if (w_accept) begin
            r_hold        <= w_full_rec;
            r_hold_valid  <= 1'b1;
            r_hold_marker <= w_is_marker;
        end else if (w_drain) begin
            r_hold_valid  <= 1'b0;
        end
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            r_pushed        <= {CNT_W{1'b0}};
            r_markers       <= 8'd0;
            r_invalid       <= 8'd0;
            r_invalid_flag  <= 1'b0;
            r_overflow_flag <= 1'b0;
        end else if (clear_flags) begin
            r_pushed        <= {CNT_W{1'b0}};
            r_markers       <= 8'd0;
            r_invalid       <= 8'd0;
            r_invalid_flag  <= 1'b0;
            r_overflow_flag <= 1'b0;
        end else begin
            if (w_drain) begin
                r_pushed <= r_pushed + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_drain && r_hold_marker && (r_markers != 8'hFF)) begin
                r_markers <= r_markers + 8'd1;
            end
            if (w_invalid && (r_invalid != 8'hFF)) begin
                r_invalid <= r_invalid + 8'd1;
            end
            if (w_invalid) begin
                r_invalid_flag <= 1'b1;
            end
            if (w_overflow) begin
                r_overflow_flag <= 1'b1;
            end
        end
    end

    assign rec_data       = r_hold;
    assign rec_write      = w_drain;
    assign word_index     = r_word_idx;
    assign records_pushed = r_pushed;
    assign markers_pushed = r_markers;
    assign invalid_count  = r_invalid;
    assign invalid_flag   = r_invalid_flag;
    assign overflow_flag  = r_overflow_flag;

endmodule
